multi_timer: RTL and testbench

- Parametrised, multi-channel successor to the single-compare machine timer.
- NUM_CH independent up-counters share one programmable prescaler.
- Each channel has its own compare value, periodic/one-shot mode, sticky pending flag and interrupt enable.
- Sits beside the core as the platform timer.
- Registers are written through a simple write strobe interface.
- Pending flags are ORed into one interrupt line for the interrupt controller.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/timer_channel.sv | 71 +++++++
 rtl/multi_timer.sv | 78 +++++++
 tb/tb_multi_timer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel platform timer: CTRL bit layout,
// register select encodings and counting modes.
package timer_pkg;

   localparam int CTRL_W    = 3;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IE   = 2;

   typedef enum logic [1:0] {
      SEL_CTRL = 2'd0,
      SEL_CMP  = 2'd1,
      SEL_CNT  = 2'd2,
      SEL_RSVD = 2'd3
   } wr_sel_e;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, compare, CTRL and sticky pending flag.
// Register writes take priority over counting in the same cycle.
module timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_i,
   input  logic              wr_ctrl_i,
   input  logic              wr_cmp_i,
   input  logic              wr_cnt_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              irq_clr_i,
   output logic [WIDTH-1:0]  count_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              pending_o
);

   logic [WIDTH-1:0]  count_q, count_d;
   logic [WIDTH-1:0]  cmp_q, cmp_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              pending_q, pending_d;

   always_comb begin
      count_d   = count_q;
      cmp_d     = cmp_q;
      ctrl_d    = ctrl_q;
      pending_d = pending_q;
      // Clear first so a match in the same cycle re-sets the flag.
      if (irq_clr_i) pending_d = 1'b0;
      if (wr_cnt_i) begin
         count_d = wr_data_i;
      end else if (wr_cmp_i) begin
         cmp_d = wr_data_i;
      end else if (wr_ctrl_i) begin
         ctrl_d = wr_data_i[CTRL_W-1:0];
      end else if (ctrl_q[CTRL_EN] && tick_i) begin
         if (count_q == cmp_q) begin
            pending_d = 1'b1;
            if (ctrl_q[CTRL_MODE] == MODE_ONESHOT) begin
               ctrl_d[CTRL_EN] = 1'b0;
            end else begin
               count_d = '0;
            end
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         cmp_q     <= '1;
         ctrl_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         cmp_q     <= cmp_d;
         ctrl_q    <= ctrl_d;
         pending_q <= pending_d;
      end
   end

   assign count_o   = count_q;
   assign ctrl_o    = ctrl_q;
   assign pending_o = pending_q;

endmodule

// File: rtl/multi_timer.sv
// Platform timer: NUM_CH independent channels driven by one shared prescaler,
// with per-channel pending flags combined into a single registered irq.
module multi_timer
   import timer_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NUM_CH     = 4,
   parameter int PRESCALE_W = 8,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PRESCALE_W-1:0]    prescale,
   input  logic                     wr_en,
   input  logic [CH_W-1:0]          wr_ch,
   input  logic [1:0]               wr_sel,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [NUM_CH-1:0]        irq_clr,
   output logic [NUM_CH*WIDTH-1:0]  count_o,
   output logic [NUM_CH-1:0]        pending_o,
   output logic [NUM_CH*CTRL_W-1:0] ctrl_o,
   output logic                     irq
);

   logic [PRESCALE_W-1:0] psc_q, psc_d;
   logic                  tick;
   logic [NUM_CH-1:0]     ie_vec;
   logic                  irq_q, irq_d;
   wr_sel_e               sel;

   // Equality only: a prescale lowered below psc makes psc wrap through all-ones.
   assign tick  = (psc_q == prescale);
   assign psc_d = tick ? '0 : psc_q + PRESCALE_W'(1);
   assign sel   = wr_sel_e'(wr_sel);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);
         logic              hit;
         logic [CTRL_W-1:0] ctrl_ch;

         assign hit = wr_en && (wr_ch == CH_IDX);

         timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick_i    (tick),
            .wr_ctrl_i (hit && (sel == SEL_CTRL)),
            .wr_cmp_i  (hit && (sel == SEL_CMP)),
            .wr_cnt_i  (hit && (sel == SEL_CNT)),
            .wr_data_i (wr_data),
            .irq_clr_i (irq_clr[gi]),
            .count_o   (count_o[gi*WIDTH +: WIDTH]),
            .ctrl_o    (ctrl_ch),
            .pending_o (pending_o[gi])
         );

         assign ctrl_o[gi*CTRL_W +: CTRL_W] = ctrl_ch;
         assign ie_vec[gi] = ctrl_ch[CTRL_IE];
      end
   endgenerate

   assign irq_d = |(pending_o & ie_vec);

   always_ff @(posedge clk) begin
      if (reset) begin
         psc_q <= '0;
         irq_q <= 1'b0;
      end else begin
         psc_q <= psc_d;
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer with hand-computed expectations.
module tb_multi_timer;

   localparam int WIDTH = 32;
   localparam int NUM_CH = 4;
   localparam int PRESCALE_W = 8;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [PRESCALE_W-1:0] prescale = '0;
   logic                 wr_en = 1'b0;
   logic [1:0]           wr_ch = '0;
   logic [1:0]           wr_sel = '0;
   logic [WIDTH-1:0]     wr_data = '0;
   logic [NUM_CH-1:0]    irq_clr = '0;
   logic [NUM_CH*WIDTH-1:0] count_o;
   logic [NUM_CH-1:0]    pending_o;
   logic [NUM_CH*3-1:0]  ctrl_o;
   logic                 irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_timer #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .PRESCALE_W(PRESCALE_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .prescale  (prescale),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .irq_clr   (irq_clr),
      .count_o   (count_o),
      .pending_o (pending_o),
      .ctrl_o    (ctrl_o),
      .irq       (irq)
   );

   function automatic logic [WIDTH-1:0] cnt(input int ch);
      return count_o[ch*WIDTH +: WIDTH];
   endfunction

   function automatic logic [2:0] ctl(input int ch);
      return ctrl_o[ch*3 +: 3];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int sel, input logic [WIDTH-1:0] data);
      wr_en = 1'b1; wr_ch = 2'(ch); wr_sel = 2'(sel); wr_data = data;
      step();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (count_o !== '0 || pending_o !== '0 || ctrl_o !== '0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset: count=%h pend=%b ctrl=%h irq=%b, want all zero",
                  count_o, pending_o, ctrl_o, irq);
      end
      $display("test_reset done");
   endtask

   task automatic test_periodic();
      logic [WIDTH-1:0] exp_cnt [5] = '{1, 2, 3, 0, 1};
      logic             exp_pnd [5] = '{0, 0, 0, 1, 1};
      logic             exp_irq [5] = '{0, 0, 0, 0, 1};
      wr(0, 1, 3);
      wr(0, 0, 32'b101);
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (cnt(0) !== exp_cnt[i] || pending_o[0] !== exp_pnd[i] || irq !== exp_irq[i]) begin
            errors++;
            $display("FAIL periodic[%0d]: cnt=%0d pend=%b irq=%b, want cnt=%0d pend=%b irq=%b",
                     i, cnt(0), pending_o[0], irq, exp_cnt[i], exp_pnd[i], exp_irq[i]);
         end
      end
      irq_clr[0] = 1'b1;
      step();
      irq_clr[0] = 1'b0;
      checks++;
      if (pending_o[0] !== 1'b0 || irq !== 1'b1 || cnt(0) !== 2) begin
         errors++;
         $display("FAIL periodic_clr: pend=%b irq=%b cnt=%0d, want pend=0 irq=1 cnt=2",
                  pending_o[0], irq, cnt(0));
      end
      step();
      checks++;
      if (irq !== 1'b0 || cnt(0) !== 3) begin
         errors++;
         $display("FAIL periodic_irq_drop: irq=%b cnt=%0d, want irq=0 cnt=3", irq, cnt(0));
      end
      // CTRL write on the would-be match edge: no match, no pending
      wr(0, 0, 0);
      checks++;
      if (cnt(0) !== 3 || pending_o[0] !== 1'b0 || ctl(0) !== 3'b000) begin
         errors++;
         $display("FAIL ctrl_priority: cnt=%0d pend=%b ctrl=%b, want cnt=3 pend=0 ctrl=000",
                  cnt(0), pending_o[0], ctl(0));
      end
      // Reserved select must be ignored
      wr(0, 3, 32'h7);
      checks++;
      if (cnt(0) !== 3 || ctl(0) !== 3'b000) begin
         errors++;
         $display("FAIL rsvd_ignored: cnt=%0d ctrl=%b, want cnt=3 ctrl=000", cnt(0), ctl(0));
      end
      $display("test_periodic done");
   endtask

   task automatic test_collision();
      wr(0, 2, 0);
      wr(0, 0, 32'b101);
      step(); step(); step();
      irq_clr[0] = 1'b1;
      step();
      irq_clr[0] = 1'b0;
      checks++;
      if (pending_o[0] !== 1'b1 || cnt(0) !== 0) begin
         errors++;
         $display("FAIL collision_set_wins: pend=%b cnt=%0d, want pend=1 cnt=0",
                  pending_o[0], cnt(0));
      end
      step();
      irq_clr[0] = 1'b1;
      step();
      irq_clr[0] = 1'b0;
      checks++;
      if (pending_o[0] !== 1'b0 || irq !== 1'b1) begin
         errors++;
         $display("FAIL collision_clear: pend=%b irq=%b, want pend=0 irq=1", pending_o[0], irq);
      end
      step();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL collision_irq_drop: irq=%b, want 0", irq);
      end
      wr(0, 0, 0);
      $display("test_collision done");
   endtask

   task automatic test_prescaler();
      logic [WIDTH-1:0] exp_cnt [4] = '{1, 1, 1, 0};
      prescale = 8'd2;
      reset = 1'b1;
      step();
      reset = 1'b0;
      wr(1, 1, 1);
      wr(1, 0, 32'b001);
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (cnt(1) !== exp_cnt[i]) begin
            errors++;
            $display("FAIL prescale_cnt[%0d]: cnt=%0d, want %0d", i, cnt(1), exp_cnt[i]);
         end
      end
      checks++;
      if (pending_o[1] !== 1'b1 || irq !== 1'b0) begin
         errors++;
         $display("FAIL prescale_match_masked: pend=%b irq=%b, want pend=1 irq=0",
                  pending_o[1], irq);
      end
      step();
      prescale = 8'd0;
      for (int i = 0; i < 255; i++) step();
      checks++;
      if (cnt(1) !== 0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL prescale_wrap_wait: cnt=%0d irq=%b, want cnt=0 irq=0", cnt(1), irq);
      end
      step();
      checks++;
      if (cnt(1) !== 1) begin
         errors++;
         $display("FAIL prescale_wrap_tick: cnt=%0d, want 1", cnt(1));
      end
      wr(1, 0, 32'b100);
      checks++;
      if (pending_o[1] !== 1'b1 || irq !== 1'b0 || ctl(1) !== 3'b100 || cnt(1) !== 1) begin
         errors++;
         $display("FAIL mask_ctrl_write: pend=%b irq=%b ctrl=%b cnt=%0d, want pend=1 irq=0 ctrl=100 cnt=1",
                  pending_o[1], irq, ctl(1), cnt(1));
      end
      step();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL mask_ie_raise: irq=%b, want 1", irq);
      end
      irq_clr[1] = 1'b1;
      step();
      irq_clr[1] = 1'b0;
      step();
      checks++;
      if (irq !== 1'b0 || pending_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL mask_clear: irq=%b pend=%b, want 0 0", irq, pending_o[1]);
      end
      $display("test_prescaler done");
   endtask

   task automatic test_oneshot();
      wr(2, 1, 5);
      wr(2, 0, 32'b011);
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (cnt(2) !== 5 || pending_o[2] !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_reach: cnt=%0d pend=%b, want cnt=5 pend=0", cnt(2), pending_o[2]);
      end
      step();
      checks++;
      if (cnt(2) !== 5 || pending_o[2] !== 1'b1 || ctl(2) !== 3'b010) begin
         errors++;
         $display("FAIL oneshot_stop: cnt=%0d pend=%b ctrl=%b, want cnt=5 pend=1 ctrl=010",
                  cnt(2), pending_o[2], ctl(2));
      end
      irq_clr[2] = 1'b1;
      step();
      irq_clr[2] = 1'b0;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (cnt(2) !== 5 || pending_o[2] !== 1'b0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_hold: cnt=%0d pend=%b irq=%b, want cnt=5 pend=0 irq=0",
                  cnt(2), pending_o[2], irq);
      end
      wr(2, 0, 32'b011);
      step();
      checks++;
      if (cnt(2) !== 5 || pending_o[2] !== 1'b1 || ctl(2) !== 3'b010) begin
         errors++;
         $display("FAIL oneshot_rearm: cnt=%0d pend=%b ctrl=%b, want cnt=5 pend=1 ctrl=010",
                  cnt(2), pending_o[2], ctl(2));
      end
      $display("test_oneshot done");
   endtask

   task automatic test_wrap_priority();
      wr(3, 2, 32'hFFFF_FFFE);
      wr(3, 0, 32'b001);
      step();
      checks++;
      if (cnt(3) !== 32'hFFFF_FFFF || pending_o[3] !== 1'b0) begin
         errors++;
         $display("FAIL wrap_pre: cnt=%h pend=%b, want ffffffff 0", cnt(3), pending_o[3]);
      end
      step();
      checks++;
      if (cnt(3) !== 0 || pending_o[3] !== 1'b1) begin
         errors++;
         $display("FAIL wrap_match: cnt=%h pend=%b, want 0 1", cnt(3), pending_o[3]);
      end
      irq_clr[3] = 1'b1;
      wr(3, 2, 100);
      irq_clr[3] = 1'b0;
      checks++;
      if (cnt(3) !== 100 || pending_o[3] !== 1'b0) begin
         errors++;
         $display("FAIL cnt_write_priority: cnt=%0d pend=%b, want 100 0", cnt(3), pending_o[3]);
      end
      step();
      checks++;
      if (cnt(3) !== 101) begin
         errors++;
         $display("FAIL cnt_after_write: cnt=%0d, want 101", cnt(3));
      end
      wr(3, 0, 0);
      wr(3, 1, 5);
      wr(3, 2, 32'hFFFF_FFFF);
      wr(3, 0, 32'b001);
      step();
      checks++;
      if (cnt(3) !== 0 || pending_o[3] !== 1'b0) begin
         errors++;
         $display("FAIL silent_wrap: cnt=%h pend=%b, want 0 0", cnt(3), pending_o[3]);
      end
      $display("test_wrap_priority done");
   endtask

   task automatic test_reset_midcount();
      step(); step();
      checks++;
      if (cnt(3) !== 2) begin
         errors++;
         $display("FAIL midcount_running: cnt=%0d, want 2", cnt(3));
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (count_o !== '0 || pending_o !== '0 || ctrl_o !== '0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL midcount_reset: count=%h pend=%b ctrl=%h irq=%b, want all zero",
                  count_o, pending_o, ctrl_o, irq);
      end
      step();
      checks++;
      if (count_o !== '0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: count=%h irq=%b, want 0 0", count_o, irq);
      end
      $display("test_reset_midcount done");
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_collision();
      test_prescaler();
      test_oneshot();
      test_wrap_priority();
      test_reset_midcount();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
